// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and load/store (LS) requesters.
// One transaction at a time: grant, issue, wait for ack or timeout, route the response back.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic              bus_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned StW = $clog2(STARVE_MAX + 1);
  localparam int unsigned ToW = $clog2(TIMEOUT + 1);
  localparam logic [StW-1:0] StarveMax   = StW'(STARVE_MAX);
  localparam logic [ToW-1:0] TimeoutLast = ToW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyLs} state_e;

  state_e            state_q;
  logic [StW-1:0]    starve_q;
  logic [ToW-1:0]    tmo_q;
  logic              if_gnt_q, ls_gnt_q, if_rvalid_q, ls_rvalid_q, bus_err_q;
  logic              mem_req_q, mem_we_q;
  logic [DATA_W-1:0] if_rdata_q, ls_rdata_q, mem_wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic              if_win, ls_win, busy_done;
  logic [StW-1:0]    starve_inc;
  logic [DATA_W-1:0] resp_data;

  always_comb begin
    // LS has priority unless IF has been passed over STARVE_MAX times in a row
    if_win     = if_req_i && (!ls_req_i || (starve_q == StarveMax));
    ls_win     = ls_req_i && !if_win;
    starve_inc = (starve_q == StarveMax) ? starve_q : starve_q + 1'b1;
    busy_done  = mem_ack_i || (tmo_q == TimeoutLast);
    resp_data  = mem_ack_i ? mem_rdata_i : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      tmo_q       <= '0;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      bus_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      mem_wdata_q <= '0;
      mem_addr_q  <= '0;
    end else begin
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      bus_err_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          tmo_q <= '0;
          if (if_win) begin
            state_q    <= StBusyIf;
            if_gnt_q   <= 1'b1;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= if_addr_i;
            starve_q   <= '0;
          end else if (ls_win) begin
            state_q     <= StBusyLs;
            ls_gnt_q    <= 1'b1;
            mem_req_q   <= 1'b1;
            mem_we_q    <= ls_we_i;
            mem_addr_q  <= ls_addr_i;
            mem_wdata_q <= ls_wdata_i;
            starve_q    <= if_req_i ? starve_inc : '0;
          end
        end
        StBusyIf, StBusyLs: begin
          if (busy_done) begin
            state_q   <= StIdle;
            bus_err_q <= !mem_ack_i;
            if (state_q == StBusyIf) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= resp_data;
            end else begin
              ls_rvalid_q <= 1'b1;
              ls_rdata_q  <= resp_data;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign if_gnt_o    = if_gnt_q;
  assign ls_gnt_o    = ls_gnt_q;
  assign if_rvalid_o = if_rvalid_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign bus_err_o   = bus_err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model (arbitration count, reference memory).
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 16;

  logic        clk, rst_n;
  logic        if_req, if_gnt, if_rvalid;
  logic [8:0]  if_addr;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [8:0]  ls_addr;
  logic [31:0] ls_wdata, ls_rdata;
  logic        bus_err, mem_req, mem_we, mem_ack;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem_m [512];  // memory model, written with what the DUT puts on the bus
  logic [31:0] ref_m [512];  // reference contents, written with what requesters intended
  int          starve_m;
  logic [31:0] last_if, last_ls;

  mem_port_arbiter dut (
    .clk_i      (clk),
    .reset_ni   (rst_n),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .if_gnt_o   (if_gnt),
    .if_rvalid_o(if_rvalid),
    .if_rdata_o (if_rdata),
    .ls_req_i   (ls_req),
    .ls_we_i    (ls_we),
    .ls_addr_i  (ls_addr),
    .ls_wdata_i (ls_wdata),
    .ls_gnt_o   (ls_gnt),
    .ls_rvalid_o(ls_rvalid),
    .ls_rdata_o (ls_rdata),
    .bus_err_o  (bus_err),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_ack_i  (mem_ack),
    .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, required finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; if_req = 1'b0; ls_req = 1'b0; mem_ack = 1'b0;
    step(); step();
    rst_n = 1'b1;
    starve_m = 0; last_if = '0; last_ls = '0;
  endtask

  // who: 0 none, 1 IF, 2 LS, 3 both
  task automatic await_grant(output int who, output int cyc);
    who = 0; cyc = 0;
    while (who == 0 && cyc < 40) begin
      step(); cyc++;
      if (if_gnt) who = who | 1;
      if (ls_gnt) who = who | 2;
    end
  endtask

  // Acts as the memory: acks d cycles after mem_req with data (d == 0: never acks).
  task automatic await_resp(input int d, input logic [31:0] data, output int who,
                            output logic [31:0] rd, output bit err, output int cyc,
                            output bit held);
    logic [8:0]  a0;
    logic        we0;
    logic [31:0] wd0;
    a0 = mem_addr; we0 = mem_we; wd0 = mem_wdata;
    who = 0; cyc = 0; held = 1'b1; rd = '0; err = 1'b0;
    while (who == 0 && cyc < 40) begin
      step(); cyc++;
      if (if_rvalid) who = who | 1;
      if (ls_rvalid) who = who | 2;
      if (who != 0) begin
        rd  = if_rvalid ? if_rdata : ls_rdata;
        err = bus_err;
      end else if (mem_req || mem_addr !== a0 || mem_we !== we0 || mem_wdata !== wd0) begin
        held = 1'b0;
      end
      mem_ack   = (who == 0 && cyc == d);
      mem_rdata = mem_ack ? data : $urandom;
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    int who, cyc, rwho, rcyc;
    bit err, held;
    logic [31:0] rd;
    logic [111:0] outs;
    rst_n = 1'b0; if_req = 1'b1; ls_req = 1'b1; mem_ack = 1'b0;
    if_addr = 9'h001; ls_addr = 9'h002; ls_we = 1'b0; ls_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      outs = {if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, bus_err,
              mem_req, mem_we, mem_addr, mem_wdata};
      vectors++;
      if (outs !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d: got %h, required 0", i, outs);
      end
    end
    rst_n = 1'b1; starve_m = 0; last_if = '0; last_ls = '0;
    await_grant(who, cyc);
    vectors++;
    if (who !== 2 || cyc !== 1) begin
      miscompares++;
      $display("FAIL reset_first_grant: got who=%0d cyc=%0d, required who=2 cyc=1", who, cyc);
    end
    if_req = 1'b0; ls_req = 1'b0;
    await_resp(1, 32'h1234, rwho, rd, err, rcyc, held);
    vectors++;
    if (rwho !== 2) begin
      miscompares++;
      $display("FAIL reset_first_resp: got who=%0d, required 2", rwho);
    end
  endtask

  task automatic test_if_fetch();
    int who, cyc, rwho, rcyc;
    bit err, held;
    logic [31:0] rd;
    do_reset();
    if_addr = 9'h010; if_req = 1'b1;
    await_grant(who, cyc);
    if_req = 1'b0;
    vectors++;
    if (who !== 1 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 9'h010) begin
      miscompares++;
      $display("FAIL if_grant: got who=%0d req=%b we=%b addr=%h, required 1 1 0 010",
               who, mem_req, mem_we, mem_addr);
    end
    await_resp(1, 32'h00500093, rwho, rd, err, rcyc, held);
    vectors++;
    if (rwho !== 1 || rd !== 32'h00500093 || err !== 1'b0 || rcyc !== 2) begin
      miscompares++;
      $display("FAIL if_resp: got who=%0d rdata=%h err=%b cyc=%0d, required 1 00500093 0 2",
               rwho, rd, err, rcyc);
    end
  endtask

  task automatic test_store_load();
    int who, cyc, rwho, rcyc;
    bit err, held;
    logic [31:0] rd;
    do_reset();
    ls_we = 1'b1; ls_addr = 9'h020; ls_wdata = 32'hDEADBEEF; ls_req = 1'b1;
    await_grant(who, cyc);
    ls_req = 1'b0;
    vectors++;
    if (who !== 2 || mem_we !== 1'b1 || mem_addr !== 9'h020 || mem_wdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL store_grant: got who=%0d we=%b addr=%h wdata=%h, required 2 1 020 deadbeef",
               who, mem_we, mem_addr, mem_wdata);
    end
    if (who == 2) mem_m[mem_addr] = mem_wdata;
    await_resp(3, 32'h0, rwho, rd, err, rcyc, held);
    vectors++;
    if (rwho !== 2 || !held || err !== 1'b0 || rcyc !== 4) begin
      miscompares++;
      $display("FAIL store_resp: got who=%0d held=%b err=%b cyc=%0d, required 2 1 0 4",
               rwho, held, err, rcyc);
    end
    ls_we = 1'b0; ls_addr = 9'h020; ls_req = 1'b1;
    await_grant(who, cyc);
    ls_req = 1'b0;
    await_resp(2, mem_m[mem_addr], rwho, rd, err, rcyc, held);
    vectors++;
    if (rwho !== 2 || rd !== 32'hDEADBEEF || err !== 1'b0) begin
      miscompares++;
      $display("FAIL load_resp: got who=%0d rdata=%h err=%b, required 2 deadbeef 0",
               rwho, rd, err);
    end
  endtask

  task automatic test_starvation();
    int who, cyc, rwho, rcyc;
    bit err, held;
    logic [31:0] rd;
    int exp_seq [6] = '{2, 2, 2, 2, 1, 2};
    do_reset();
    if_addr = 9'h100; ls_addr = 9'h050; ls_we = 1'b0; if_req = 1'b1; ls_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      await_grant(who, cyc);
      if (who == 1) if_req = 1'b0;
      if (k == 5) ls_req = 1'b0;
      vectors++;
      if (who !== exp_seq[k]) begin
        miscompares++;
        $display("FAIL starve_grant %0d: got who=%0d, required %0d", k, who, exp_seq[k]);
      end
      await_resp(1, mem_m[mem_addr], rwho, rd, err, rcyc, held);
    end
  endtask

  task automatic test_timeout();
    int who, cyc, rwho, rcyc;
    bit err, held;
    logic [31:0] rd;
    do_reset();
    ls_we = 1'b0; ls_addr = 9'h030; ls_req = 1'b1;
    await_grant(who, cyc);
    ls_req = 1'b0;
    await_resp(0, 32'h0, rwho, rd, err, rcyc, held);
    vectors++;
    if (rwho !== 2 || err !== 1'b1 || rd !== 32'h0 || rcyc !== TIMEOUT) begin
      miscompares++;
      $display("FAIL timeout_resp: got who=%0d err=%b rdata=%h cyc=%0d, required 2 1 0 %0d",
               rwho, err, rd, rcyc, TIMEOUT);
    end
    if_addr = 9'h040; if_req = 1'b1;
    await_grant(who, cyc);
    if_req = 1'b0;
    vectors++;
    if (who !== 1 || cyc !== 1) begin
      miscompares++;
      $display("FAIL timeout_next_grant: got who=%0d cyc=%0d, required 1 1", who, cyc);
    end
    await_resp(2, mem_m[9'h040], rwho, rd, err, rcyc, held);
    vectors++;
    if (rwho !== 1 || rd !== ref_m[9'h040] || err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_next_resp: got who=%0d rdata=%h err=%b, required 1 %h 0",
               rwho, rd, err, ref_m[9'h040]);
    end
  endtask

  task automatic test_reset_mid();
    int who, cyc, stray;
    do_reset();
    ls_we = 1'b0; ls_addr = 9'h060; ls_req = 1'b1;
    await_grant(who, cyc);
    ls_req = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; starve_m = 0; last_if = '0; last_ls = '0;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      mem_ack = (i == 1); mem_rdata = 32'hBAD0BAD0;
      if (if_rvalid || ls_rvalid || bus_err || if_gnt || ls_gnt || mem_req) stray++;
    end
    mem_ack = 1'b0;
    vectors++;
    if (stray !== 0 || ls_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_stray: got %0d activity cycles rdata=%h, required 0 0",
               stray, ls_rdata);
    end
    if_addr = 9'h070; if_req = 1'b1;
    await_grant(who, cyc);
    if_req = 1'b0;
    vectors++;
    if (who !== 1 || cyc !== 1) begin
      miscompares++;
      $display("FAIL reset_mid_next_grant: got who=%0d cyc=%0d, required 1 1", who, cyc);
    end
    mem_ack = 1'b0;
    for (int i = 0; i < 20; i++) step();  // let the abandoned-free IF fetch time out quietly
  endtask

  task automatic test_random();
    int who, cyc, rwho, rcyc, exp_who, d;
    bit err, held, is_store;
    logic [8:0]  ga, ia;
    logic [31:0] rd, exp_rd, gwd, iwd;
    do_reset();
    for (int it = 0; it < 60; it++) begin
      if (!if_req && $urandom_range(0, 1) == 1) begin
        if_addr = 9'($urandom_range(0, 15)); if_req = 1'b1;
      end
      if (!ls_req && ($urandom_range(0, 1) == 1 || !if_req)) begin
        ls_addr = 9'($urandom_range(0, 15)); ls_we = 1'($urandom);
        ls_wdata = $urandom; ls_req = 1'b1;
      end
      exp_who = (if_req && (!ls_req || starve_m == STARVE_MAX)) ? 1 : 2;
      is_store = (exp_who == 2) && ls_we;
      ia  = (exp_who == 1) ? if_addr : ls_addr;
      iwd = ls_wdata;
      if (exp_who == 1) starve_m = 0;
      else starve_m = if_req ? ((starve_m == STARVE_MAX) ? starve_m : starve_m + 1) : 0;
      await_grant(who, cyc);
      ga = mem_addr; gwd = mem_wdata;
      vectors++;
      if (who !== exp_who || mem_req !== 1'b1 || mem_addr !== ia || mem_we !== is_store ||
          (is_store && mem_wdata !== iwd)) begin
        miscompares++;
        $display("FAIL rand_grant %0d: got who=%0d req=%b addr=%h we=%b wd=%h, req %0d 1 %h %b %h",
                 it, who, mem_req, mem_addr, mem_we, mem_wdata, exp_who, ia, is_store, iwd);
      end
      vectors++;
      if (if_rvalid || ls_rvalid || if_rdata !== last_if || ls_rdata !== last_ls) begin
        miscompares++;
        $display("FAIL rand_hold %0d: got rv=%b%b rd=%h/%h, required 00 %h/%h", it,
                 if_rvalid, ls_rvalid, if_rdata, ls_rdata, last_if, last_ls);
      end
      if (exp_who == 1) if_req = 1'b0; else ls_req = 1'b0;
      d = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      exp_rd = (d == 0) ? 32'h0 : (is_store ? mem_m[ga] : ref_m[ia]);
      await_resp(d, mem_m[ga], rwho, rd, err, rcyc, held);
      vectors++;
      if (rwho !== exp_who || rd !== exp_rd || err !== (d == 0) || !held ||
          rcyc !== ((d == 0) ? TIMEOUT : d + 1)) begin
        miscompares++;
        $display("FAIL rand_resp %0d: got who=%0d rd=%h err=%b held=%b cyc=%0d, req %0d %h %b 1 %0d",
                 it, rwho, rd, err, held, rcyc, exp_who, exp_rd, (d == 0),
                 (d == 0) ? TIMEOUT : d + 1);
      end
      if (exp_who == 1) last_if = exp_rd; else last_ls = exp_rd;
      if (is_store && d != 0) begin
        mem_m[ga] = gwd;
        ref_m[ia] = iwd;
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 512; i++) begin
      v = $urandom; mem_m[i] = v; ref_m[i] = v;
    end
    mem_ack = 1'b0; mem_rdata = '0;
    if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    test_reset();
    test_if_fetch();
    test_store_load();
    test_starvation();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
